// File: rtl/axis_capture_pkg.sv
// Shared types and default sizing for the AXI-Stream frame capture block.
package axis_capture_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned DEPTH_DEF     = 64;
    localparam int unsigned FRAME_LEN_DEF = 52;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Magnitude of a signed 16-bit sample; -32768 has no positive twin and saturates.
    function automatic logic [14:0] abs_sat16(input logic [15:0] s);
        if (s == 16'h8000) begin
            return 15'h7fff;
        end
        return s[15] ? 15'(~s[14:0] + 15'd1) : s[14:0];
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port single-clock RAM with a read-first registered read port.
module capture_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write port; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port samples the pre-write word, so a colliding write returns old data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/axis_frame_capture.sv
// Captures one AXI-Stream frame per arm pulse into a buffer, tracking length errors and peak magnitude.
module axis_frame_capture
    import axis_capture_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned FRAME_LEN = FRAME_LEN_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [DATA_W-1:0]        S_AXIS_tdata,
    input  logic                     S_AXIS_tvalid,
    input  logic                     S_AXIS_tlast,
    output logic                     S_AXIS_tready,
    input  logic                     arm,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   beat_count,
    output logic [14:0]              peak_abs,
    output logic                     err_short,
    output logic                     err_long,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LAST_IDX_C  = CW'(DEPTH - 1);

    state_e        state_q;
    logic [CW-1:0] beat_count_q;
    logic [CW-1:0] beat_count_d;
    logic [14:0]   peak_abs_q;
    logic [14:0]   sample_abs_d;
    logic          frame_done_q;
    logic          err_short_q;
    logic          err_long_q;
    logic          overflow_q;
    logic          accept_c;
    logic          store_c;

    // Ready depends only on state so it never drops mid-frame until the frame ends.
    assign S_AXIS_tready = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);
    assign accept_c      = S_AXIS_tvalid && S_AXIS_tready;
    assign store_c       = accept_c && (state_q == ST_CAPTURE);

    // Saturating next beat count and magnitude of the incoming sample.
    always_comb begin
        beat_count_d = (&beat_count_q) ? beat_count_q : beat_count_q + CW'(1);
        sample_abs_d = abs_sat16(S_AXIS_tdata[15:0]);
    end

    // Capture control FSM with registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            beat_count_q <= '0;
            peak_abs_q   <= '0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        state_q      <= ST_CAPTURE;
                        beat_count_q <= '0;
                        peak_abs_q   <= '0;
                        frame_done_q <= 1'b0;
                        err_short_q  <= 1'b0;
                        err_long_q   <= 1'b0;
                        overflow_q   <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept_c) begin
                        beat_count_q <= beat_count_d;
                        if (sample_abs_d > peak_abs_q) begin
                            peak_abs_q <= sample_abs_d;
                        end
                        if (beat_count_d > FRAME_LEN_C) begin
                            err_long_q <= 1'b1;
                        end
                        if (S_AXIS_tlast) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                            if (beat_count_d < FRAME_LEN_C) begin
                                err_short_q <= 1'b1;
                            end
                        end else if (beat_count_q == LAST_IDX_C) begin
                            state_q    <= ST_DRAIN;
                            overflow_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept_c) begin
                        beat_count_q <= beat_count_d;
                        if (beat_count_d > FRAME_LEN_C) begin
                            err_long_q <= 1'b1;
                        end
                        if (S_AXIS_tlast) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                            if (beat_count_d < FRAME_LEN_C) begin
                                err_short_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .we_i    (store_c),
        .waddr_i (beat_count_q[AW-1:0]),
        .wdata_i (S_AXIS_tdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_done = frame_done_q;
    assign beat_count = beat_count_q;
    assign peak_abs   = peak_abs_q;
    assign err_short  = err_short_q;
    assign err_long   = err_long_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_axis_frame_capture.sv
// Bench for axis_frame_capture: per-cycle comparison against a frame-level model plus literal checks.
module tb_axis_frame_capture;

    localparam int DEP = 64;
    localparam int FL  = 52;

    logic        clk;
    logic        resetn;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tlast;
    logic        tready;
    logic        arm;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        frame_done;
    logic [6:0]  beat_count;
    logic [14:0] peak_abs;
    logic        err_short;
    logic        err_long;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 0;

    axis_frame_capture #(.DATA_W(32), .DEPTH(DEP), .FRAME_LEN(FL)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXIS_tdata  (tdata),
        .S_AXIS_tvalid (tvalid),
        .S_AXIS_tlast  (tlast),
        .S_AXIS_tready (tready),
        .arm           (arm),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .frame_done    (frame_done),
        .beat_count    (beat_count),
        .peak_abs      (peak_abs),
        .err_short     (err_short),
        .err_long      (err_long),
        .overflow      (overflow)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    logic [31:0] m_mem [DEP];
    bit          m_wr  [DEP];
    bit          m_active = 0;
    bit          m_done   = 0;
    bit          m_es     = 0;
    bit          m_el     = 0;
    bit          m_ov     = 0;
    int          m_cnt    = 0;
    int          m_peak   = 0;
    logic [31:0] m_rd     = '0;
    bit          m_rd_ok  = 0;

    function automatic int mag(input logic [31:0] d);
        int s;
        s = int'($signed(d[15:0]));
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return s;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active = 0; m_done = 0; m_es = 0; m_el = 0; m_ov = 0;
            m_cnt = 0; m_peak = 0; m_rd = '0; m_rd_ok = 1;
        end else begin
            m_rd_ok = m_wr[rd_addr];
            m_rd    = m_mem[rd_addr];
            if (m_active && tvalid) begin
                if (m_cnt < DEP) begin
                    m_mem[m_cnt] = tdata;
                    m_wr[m_cnt]  = 1;
                    if (mag(tdata) > m_peak) m_peak = mag(tdata);
                end
                if (m_cnt == DEP - 1 && !tlast) m_ov = 1;
                m_cnt = (m_cnt >= 127) ? 127 : m_cnt + 1;
                if (m_cnt > FL) m_el = 1;
                if (tlast) begin
                    m_active = 0;
                    m_done   = 1;
                    if (m_cnt < FL) m_es = 1;
                end
            end else if (!m_active && arm) begin
                m_active = 1; m_done = 0; m_es = 0; m_el = 0; m_ov = 0;
                m_cnt = 0; m_peak = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_tready",     32'(tready),     32'(m_active));
            check("cyc_frame_done", 32'(frame_done), 32'(m_done));
            check("cyc_beat_count", 32'(beat_count), 32'(m_cnt));
            check("cyc_peak_abs",   32'(peak_abs),   32'(m_peak));
            check("cyc_err_short",  32'(err_short),  32'(m_es));
            check("cyc_err_long",   32'(err_long),   32'(m_el));
            check("cyc_overflow",   32'(overflow),   32'(m_ov));
            if (m_rd_ok) check("cyc_rd_data", rd_data, m_rd);
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic pulse_arm();
        arm = 1;
        @(negedge clk);
        arm = 0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l, input int gap);
        int  waited;
        logic rdy;
        tvalid = 0;
        tlast  = 0;
        repeat (gap) @(negedge clk);
        tdata  = d;
        tlast  = l;
        tvalid = 1;
        waited = 0;
        rdy    = 0;
        while (!rdy) begin
            rdy = tready;
            @(negedge clk);
            if (!rdy) begin
                waited++;
                if (waited > 100) begin
                    check("beat_accept_timeout", 32'(0), 32'(1));
                    rdy = 1;
                end
            end
        end
        tvalid = 0;
        tlast  = 0;
    endtask

    task automatic read_check(input string name, input logic [5:0] a, input logic [31:0] exp);
        rd_addr = a;
        @(negedge clk);
        check(name, rd_data, exp);
    endtask

    task automatic impulse_frame_and_check();
        pulse_arm();
        check("imp_tready_armed", 32'(tready), 32'(1));
        for (int i = 0; i < 52; i++) begin
            send_beat((i == 0) ? 32'h0000_7fff : 32'h0, i == 51, 0);
        end
        check("imp_frame_done", 32'(frame_done), 32'(1));
        check("imp_beat_count", 32'(beat_count), 32'd52);
        check("imp_peak_abs",   32'(peak_abs),   32'h7fff);
        check("imp_flags",      32'({err_short, err_long, overflow}), 32'(0));
        check("imp_tready_done", 32'(tready), 32'(0));
        read_check("imp_rd0", 6'd0, 32'h0000_7fff);
        for (int a = 1; a < 52; a++) read_check("imp_rd_zero", 6'(a), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        resetn = 0; tdata = '0; tvalid = 0; tlast = 0; arm = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        resetn = 1;
        cmp_en = 1;
        @(negedge clk);
        check("rst_tready",     32'(tready),     32'(0));
        check("rst_frame_done", 32'(frame_done), 32'(0));
        check("rst_beat_count", 32'(beat_count), 32'(0));

        // Impulse frame of exactly FRAME_LEN beats.
        impulse_frame_and_check();

        // 10-beat frame with random gaps, an ignored arm, and a read-first collision on entry 0.
        rd_addr = 6'd0;
        pulse_arm();
        for (int i = 0; i < 10; i++) begin
            if (i == 5) pulse_arm();
            send_beat(32'h1000 + 32'(i), i == 9, int'($urandom_range(0, 3)));
            if (i == 0) check("short_read_first", rd_data, 32'h0000_7fff);
        end
        check("short_done",       32'(frame_done), 32'(1));
        check("short_beat_count", 32'(beat_count), 32'd10);
        check("short_err_short",  32'(err_short),  32'(1));
        check("short_err_long",   32'(err_long),   32'(0));
        check("short_peak",       32'(peak_abs),   32'h1009);
        for (int a = 0; a < 10; a++) read_check("short_rd", 6'(a), 32'h1000 + 32'(a));

        // 60-beat frame: err_long rises on beat 53.
        pulse_arm();
        for (int i = 0; i < 60; i++) begin
            send_beat(32'(i + 1), i == 59, 0);
            if (i == 51) check("long_el_at52", 32'(err_long), 32'(0));
            if (i == 52) check("long_el_at53", 32'(err_long), 32'(1));
        end
        check("long_beat_count", 32'(beat_count), 32'd60);
        check("long_overflow",   32'(overflow),   32'(0));
        check("long_err_short",  32'(err_short),  32'(0));
        check("long_peak",       32'(peak_abs),   32'd60);

        // 70-beat frame: overflow after beat 64, beats 65..70 drained.
        pulse_arm();
        for (int i = 0; i < 70; i++) begin
            send_beat(32'hA000_0000 | 32'(i + 1), i == 69, 0);
            if (i == 62) check("ovf_before64", 32'(overflow), 32'(0));
            if (i == 63) begin
                check("ovf_after64",    32'(overflow), 32'(1));
                check("ovf_drain_rdy",  32'(tready),   32'(1));
            end
        end
        check("ovf_done",       32'(frame_done), 32'(1));
        check("ovf_beat_count", 32'(beat_count), 32'd70);
        check("ovf_peak",       32'(peak_abs),   32'd64);
        check("ovf_err_long",   32'(err_long),   32'(1));
        read_check("ovf_mem63", 6'd63, 32'hA000_0040);
        read_check("ovf_mem0",  6'd0,  32'hA000_0001);

        // Magnitude corner cases.
        pulse_arm();
        send_beat(32'hffff_fffe, 1'b0, 0);
        send_beat(32'h0000_0001, 1'b1, 0);
        check("abs_minus2", 32'(peak_abs), 32'd2);
        pulse_arm();
        send_beat(32'hffff_fffe, 1'b0, 0);
        send_beat(32'hffff_8000, 1'b1, 0);
        check("abs_min_sat", 32'(peak_abs),   32'h7fff);
        check("abs_count",   32'(beat_count), 32'd2);

        // Asynchronous reset in the middle of a capture, then recovery.
        pulse_arm();
        for (int i = 0; i < 20; i++) send_beat(32'h55 + 32'(i), 1'b0, 0);
        #2 resetn = 0;
        #1;
        check("arst_tready",     32'(tready),     32'(0));
        check("arst_frame_done", 32'(frame_done), 32'(0));
        check("arst_beat_count", 32'(beat_count), 32'(0));
        check("arst_peak",       32'(peak_abs),   32'(0));
        check("arst_flags",      32'({err_short, err_long, overflow}), 32'(0));
        check("arst_rd_data",    rd_data,         32'h0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        @(negedge clk);
        check("post_rst_idle", 32'(tready), 32'(0));
        impulse_frame_and_check();

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
